// File: rtl/dcache_snoop_responder.sv
// Cache-side snoop responder: looks bus search/invalidate addresses up in the
// local d-cache tag/state array, answers searches and applies MSI state updates.
module dcache_snoop_responder #(
    parameter int ADDR_W   = 13,
    parameter int INDEX_W  = 6,
    parameter int DATA_W   = 16,
    parameter int HOLD_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      snp_search,
    input  logic                      snp_inv,
    input  logic [ADDR_W-1:0]         snp_addr,
    output logic [INDEX_W-1:0]        arr_idx,
    input  logic [ADDR_W-INDEX_W-1:0] arr_tag,
    input  logic [1:0]                arr_state,
    input  logic [DATA_W-1:0]         arr_data,
    output logic                      st_we,
    output logic [INDEX_W-1:0]        st_idx,
    output logic [1:0]                st_wdata,
    output logic                      search_found,
    output logic [1:0]                block_state,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      snp_busy
);
    localparam int CNT_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [2:0] {IDLE, S_LOOK, S_HOLD, I_LOOK, I_WR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                found_q, found_d;
    logic [1:0]          bstate_q, bstate_d;
    logic [DATA_W-1:0]   fwd_q, fwd_d;
    logic                hit;

    assign hit = (arr_tag == addr_q[ADDR_W-1:INDEX_W]) && (arr_state != ST_I);
    assign snp_busy = (state_q != IDLE) | snp_search | snp_inv | pend_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        cnt_d        = cnt_q;
        found_d      = found_q;
        bstate_d     = bstate_q;
        fwd_d        = fwd_q;
        arr_idx      = addr_q[INDEX_W-1:0];
        st_we        = 1'b0;
        st_idx       = '0;
        st_wdata     = ST_I;
        search_found = 1'b0;
        block_state  = ST_I;
        fwd_data     = '0;

        // An invalidate that arrives mid-operation is parked; a newer one replaces it.
        if (state_q != IDLE && snp_inv) begin
            pend_d      = 1'b1;
            pend_addr_d = snp_addr;
        end

        case (state_q)
            IDLE: begin
                arr_idx = '0;
                if (snp_inv) begin
                    addr_d  = snp_addr;
                    arr_idx = snp_addr[INDEX_W-1:0];
                    state_d = I_LOOK;
                end else if (snp_search) begin
                    addr_d  = snp_addr;
                    arr_idx = snp_addr[INDEX_W-1:0];
                    state_d = S_LOOK;
                end else if (pend_q) begin
                    // Pending flag drops once the replay is launched, so a miss cannot re-trigger it.
                    addr_d  = pend_addr_q;
                    arr_idx = pend_addr_q[INDEX_W-1:0];
                    pend_d  = 1'b0;
                    state_d = I_LOOK;
                end
            end
            S_LOOK: begin
                if (hit) begin
                    search_found = 1'b1;
                    block_state  = arr_state;
                    fwd_data     = arr_data;
                    found_d      = 1'b1;
                    bstate_d     = arr_state;
                    fwd_d        = arr_data;
                    cnt_d        = CNT_W'(HOLD_CYC - 2);
                    state_d      = S_HOLD;
                    if (arr_state == ST_M) begin
                        st_we    = 1'b1;
                        st_idx   = addr_q[INDEX_W-1:0];
                        st_wdata = ST_S;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            S_HOLD: begin
                search_found = found_q;
                block_state  = bstate_q;
                fwd_data     = fwd_q;
                if (cnt_q == '0) begin
                    found_d  = 1'b0;
                    bstate_d = ST_I;
                    fwd_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            I_LOOK: begin
                state_d = hit ? I_WR : IDLE;
            end
            I_WR: begin
                st_we    = 1'b1;
                st_idx   = addr_q[INDEX_W-1:0];
                st_wdata = ST_I;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            bstate_q    <= ST_I;
            fwd_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            bstate_q    <= bstate_d;
            fwd_q       <= fwd_d;
        end
    end
endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: emulated tag/state/data array plus a
// transaction-level MSI reference model driven by directed and random snoops.
module tb_dcache_snoop_responder;
    localparam int ADDR_W   = 13;
    localparam int INDEX_W  = 6;
    localparam int DATA_W   = 16;
    localparam int HOLD_CYC = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W;
    localparam int LINES    = 1 << INDEX_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                snp_search = 1'b0;
    logic                snp_inv = 1'b0;
    logic [ADDR_W-1:0]   snp_addr = '0;
    logic [INDEX_W-1:0]  arr_idx;
    logic [TAG_W-1:0]    arr_tag;
    logic [1:0]          arr_state;
    logic [DATA_W-1:0]   arr_data;
    logic                st_we;
    logic [INDEX_W-1:0]  st_idx;
    logic [1:0]          st_wdata;
    logic                search_found;
    logic [1:0]          block_state;
    logic [DATA_W-1:0]   fwd_data;
    logic                snp_busy;

    int checks = 0;
    int errors = 0;

    logic [TAG_W-1:0]  tag_a  [LINES];
    logic [DATA_W-1:0] data_a [LINES];
    logic [1:0]        m_state[LINES];
    logic [1:0]        mem_state[LINES];
    logic              init_req = 1'b0;

    dcache_snoop_responder #(
        .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .snp_search(snp_search), .snp_inv(snp_inv),
        .snp_addr(snp_addr), .arr_idx(arr_idx), .arr_tag(arr_tag),
        .arr_state(arr_state), .arr_data(arr_data), .st_we(st_we),
        .st_idx(st_idx), .st_wdata(st_wdata), .search_found(search_found),
        .block_state(block_state), .fwd_data(fwd_data), .snp_busy(snp_busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read array; tag/data are static, state is written by the DUT.
    always @(posedge clk) begin
        arr_tag   <= tag_a[arr_idx];
        arr_state <= mem_state[arr_idx];
        arr_data  <= data_a[arr_idx];
        if (init_req) begin
            for (int i = 0; i < LINES; i++) mem_state[i] <= m_state[i];
        end else if (st_we) begin
            mem_state[st_idx] <= st_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_mem();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
    endtask

    task automatic set_line(input int idx, input logic [TAG_W-1:0] tg,
                            input logic [1:0] st, input logic [DATA_W-1:0] d);
        tag_a[idx]   = tg;
        data_a[idx]  = d;
        m_state[idx] = st;
        sync_mem();
    endtask

    task automatic check_mem(input int idx);
        checks++;
        if (mem_state[idx] !== m_state[idx]) begin
            errors++;
            $display("FAIL array_state[%0d]: got %b expected %b", idx, mem_state[idx], m_state[idx]);
        end
    endtask

    task automatic do_search(input logic [ADDR_W-1:0] addr);
        int idx;
        logic exp_hit, exp_dg;
        logic [1:0] exp_st;
        logic [DATA_W-1:0] exp_fwd;
        idx     = int'(addr[INDEX_W-1:0]);
        exp_hit = (tag_a[idx] == addr[ADDR_W-1:INDEX_W]) && (m_state[idx] != 2'b00);
        exp_dg  = exp_hit && (m_state[idx] == 2'b10);
        exp_st  = exp_hit ? m_state[idx] : 2'b00;
        exp_fwd = exp_hit ? data_a[idx] : '0;
        snp_addr = addr;
        snp_search = 1'b1;
        #1;
        checks++;
        if (snp_busy !== 1'b1) begin
            errors++; $display("FAIL search_busy_req: got %b expected 1", snp_busy);
        end
        step();
        snp_search = 1'b0;
        for (int k = 1; k <= HOLD_CYC; k++) begin
            checks++;
            if ({search_found, block_state, fwd_data} !== {exp_hit, exp_st, exp_fwd}) begin
                errors++;
                $display("FAIL search_resp t+%0d: got %b/%b/%h expected %b/%b/%h", k,
                         search_found, block_state, fwd_data, exp_hit, exp_st, exp_fwd);
            end
            checks++;
            if (st_we !== (exp_dg && k == 1)) begin
                errors++; $display("FAIL search_st_we t+%0d: got %b expected %b", k, st_we, exp_dg && k == 1);
            end
            if (exp_dg && k == 1) begin
                checks++;
                if ({st_idx, st_wdata} !== {INDEX_W'(idx), 2'b01}) begin
                    errors++; $display("FAIL downgrade_write: got idx %0d data %b expected idx %0d data 01",
                                       st_idx, st_wdata, idx);
                end
            end
            step();
        end
        checks++;
        if ({search_found, block_state, fwd_data, st_we, snp_busy} !== '0) begin
            errors++; $display("FAIL search_end: got found %b state %b fwd %h we %b busy %b expected all 0",
                               search_found, block_state, fwd_data, st_we, snp_busy);
        end
        if (exp_dg) m_state[idx] = 2'b01;
        check_mem(idx);
    endtask

    task automatic do_inv(input logic [ADDR_W-1:0] addr, input logic with_search);
        int idx;
        logic exp_hit;
        idx     = int'(addr[INDEX_W-1:0]);
        exp_hit = (tag_a[idx] == addr[ADDR_W-1:INDEX_W]) && (m_state[idx] != 2'b00);
        snp_addr = addr;
        snp_inv = 1'b1;
        snp_search = with_search;
        step();
        snp_inv = 1'b0;
        snp_search = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({st_we, search_found} !== {(exp_hit && k == 2), 1'b0}) begin
                errors++; $display("FAIL inv_we_found t+%0d: got we %b found %b expected we %b found 0",
                                   k, st_we, search_found, exp_hit && k == 2);
            end
            if (exp_hit && k == 2) begin
                checks++;
                if ({st_idx, st_wdata} !== {INDEX_W'(idx), 2'b00}) begin
                    errors++; $display("FAIL inv_write: got idx %0d data %b expected idx %0d data 00",
                                       st_idx, st_wdata, idx);
                end
            end
            if (k == 3) begin
                checks++;
                if (snp_busy !== 1'b0) begin
                    errors++; $display("FAIL inv_end_busy: got %b expected 0", snp_busy);
                end
            end
            step();
        end
        if (exp_hit) m_state[idx] = 2'b00;
        check_mem(idx);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({search_found, block_state, fwd_data, st_we, st_idx, st_wdata, snp_busy, arr_idx} !== '0) begin
            errors++; $display("FAIL reset_outputs: got found %b state %b fwd %h we %b busy %b idx %0d expected all 0",
                               search_found, block_state, fwd_data, st_we, snp_busy, arr_idx);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_search_shared();
        set_line(5, 7'h12, 2'b01, 16'hBEEF);
        do_search({7'h12, 6'd5});
    endtask

    task automatic test_search_modified();
        set_line(5, 7'h12, 2'b10, 16'hBEEF);
        do_search({7'h12, 6'd5});
    endtask

    task automatic test_search_miss();
        set_line(5, 7'h12, 2'b01, 16'hBEEF);
        do_search({7'h13, 6'd5});
        set_line(9, 7'h21, 2'b00, 16'h1234);
        do_search({7'h21, 6'd9});
    endtask

    task automatic test_inv_pending();
        set_line(5, 7'h12, 2'b01, 16'hBEEF);
        snp_addr = {7'h12, 6'd5};
        snp_search = 1'b1;
        step();
        snp_search = 1'b0;
        snp_inv = 1'b1;
        for (int k = 1; k <= HOLD_CYC + 4; k++) begin
            checks++;
            if (search_found !== (k <= HOLD_CYC)) begin
                errors++; $display("FAIL pend_found t+%0d: got %b expected %b", k, search_found, k <= HOLD_CYC);
            end
            checks++;
            if (st_we !== (k == HOLD_CYC + 3)) begin
                errors++; $display("FAIL pend_st_we t+%0d: got %b expected %b", k, st_we, k == HOLD_CYC + 3);
            end
            if (k == HOLD_CYC + 3) begin
                checks++;
                if ({st_idx, st_wdata} !== {6'd5, 2'b00}) begin
                    errors++; $display("FAIL pend_write: got idx %0d data %b expected idx 5 data 00", st_idx, st_wdata);
                end
            end
            checks++;
            if (snp_busy !== (k <= HOLD_CYC + 3)) begin
                errors++; $display("FAIL pend_busy t+%0d: got %b expected %b", k, snp_busy, k <= HOLD_CYC + 3);
            end
            step();
            snp_inv = 1'b0;
        end
        m_state[5] = 2'b00;
        check_mem(5);
    endtask

    task automatic test_inv_beats_search();
        set_line(7, 7'h3A, 2'b10, 16'hCAFE);
        do_inv({7'h3A, 6'd7}, 1'b1);
        set_line(7, 7'h3A, 2'b01, 16'hCAFE);
        do_inv({7'h3A, 6'd7}, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        set_line(5, 7'h12, 2'b01, 16'hBEEF);
        snp_addr = {7'h12, 6'd5};
        snp_search = 1'b1;
        step();
        snp_search = 1'b0;
        snp_inv = 1'b1;
        step();
        snp_inv = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({search_found, block_state, fwd_data, st_we, snp_busy, arr_idx} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got found %b state %b fwd %h we %b busy %b idx %0d expected all 0",
                               search_found, block_state, fwd_data, st_we, snp_busy, arr_idx);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({st_we, snp_busy, search_found} !== 3'b000) begin
                errors++; $display("FAIL midreset_after c%0d: got we %b busy %b found %b expected 000",
                                   k, st_we, snp_busy, search_found);
            end
            step();
        end
        check_mem(5);
    endtask

    task automatic test_random();
        int idx, op;
        logic [TAG_W-1:0] tg;
        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0)
                set_line(idx, tag_a[idx], 2'($urandom_range(0, 2)), data_a[idx]);
            tg = ($urandom_range(0, 3) != 0) ? tag_a[idx] : TAG_W'($urandom);
            op = int'($urandom_range(0, 2));
            if (op == 0) do_search({tg, INDEX_W'(idx)});
            else do_inv({tg, INDEX_W'(idx)}, op == 2);
        end
    endtask

    initial begin
        for (int i = 0; i < LINES; i++) begin
            tag_a[i]   = TAG_W'($urandom);
            data_a[i]  = DATA_W'($urandom);
            m_state[i] = 2'($urandom_range(0, 2));
        end
        sync_mem();
        test_reset();
        test_search_shared();
        test_search_modified();
        test_search_miss();
        test_inv_pending();
        test_inv_beats_search();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
